sp_ram_ctrl: RTL
================

Name: sp_ram_ctrl

Overview:
- Parametrised successor to the 8x16 single-port RAM.
- Adds configurable width/depth, per-byte write enables, a programmable read-latency pipeline with a valid flag, and a post-reset memory clear sweep with a ready flag.
- Detects illegal simultaneous read+write requests.
- Sits behind the existing tb-style driver: same request signal set plus ready/valid/err.

Parameters:
- data_size, 32, word width in bits; must be a multiple of 8.
- address_size, 4, address width; DEPTH = 2**address_size words.
- RD_LATENCY, 1, cycles from read acceptance to rd_valid; legal range 1..4.
- INIT_VALUE, 0, value written to every word during the init sweep (data_size bits).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select; requests are ignored when 0.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- address_in  input  address_size  word address.
- data_in  input  data_size  write data.
- byte_en  input  data_size/8  per-byte write enable; bit i covers bits [8i+7:8i].
- data_out  output  data_size  read data; registered.
- rd_valid  output  1  one-cycle pulse when data_out is updated.
- ready  output  1  high when requests are accepted.
- err  output  1  one-cycle pulse on an illegal request.

Behaviour:
- Reset (async assert, any time):
  - data_out=0, rd_valid=0, ready=0, err=0.
  - Read pipeline flushed; state=INIT; init counter=0.
  - Reset during INIT or with reads in flight aborts them; no rd_valid is produced for those reads.
- States: INIT -> IDLE only. There is no other transition except reset back to INIT.
- INIT:
  - Each edge writes INIT_VALUE to address init_cnt, all bytes, then init_cnt increments.
  - The edge that writes DEPTH-1 also sets ready=1 and moves to IDLE.
  - ready therefore rises after exactly DEPTH edges following reset deassertion.
  - cs/wr_en/rd_en are ignored in INIT; err stays 0.
- IDLE, request decode each edge (only when cs=1 and ready=1):
  - wr_en=1, rd_en=0: write; only byte lanes with byte_en=1 are updated; other lanes keep their old value. byte_en=0 means no change.
  - rd_en=1, wr_en=0: read accepted. The word is sampled from memory at this edge and enters the pipeline.
  - wr_en=1, rd_en=1: no memory access, no read issued; err=1 for the following cycle only.
  - wr_en=0, rd_en=0: no operation.
- Read latency and throughput:
  - A read accepted at edge N gives data_out = word and rd_valid=1 after edge N+RD_LATENCY-1+1. For RD_LATENCY=1, this is the cycle right after acceptance.
  - Throughput is one read per cycle; back-to-back reads give back-to-back rd_valid pulses in order.
  - Writes issued while reads are in flight do not alter data already sampled.
- Ordering: a read at edge N+1 of an address written at edge N returns the new data.
- data_out holds its last value between rd_valid pulses.
- Addresses: address_in is always in range (full decode); there is no wrap logic beyond width truncation.
- ready stays 1 after INIT until the next reset.

Optional Feature:
- Macro: SP_RAM_PARITY_EN.
- Defined:
  - Memory stores one even-parity bit per byte lane, computed from data_in on writes and the init sweep.
  - Extra input inject_par_err (1 bit): when 1 during an accepted write, stored parity of the written lanes is inverted.
  - Extra output parity_err (data_size/8 bits), reset 0, updated together with data_out. Bit i=1 if byte i fails its parity check; it is valid only while rd_valid=1 and 0 otherwise.
- Undefined: no parity storage and no inject_par_err/parity_err ports; behaviour is otherwise identical.

Test Plan:
- Release reset, hold cs=1 rd_en=1 -> ready=0 for exactly 16 edges, then 1. The first accepted read of addr 0 returns 0x00000000 with rd_valid one cycle later (defaults).
- Write 0xDEADBEEF to addr 5 with byte_en=4'b1111, then write 0x11223344 with byte_en=4'b0101, then read addr 5 -> data_out=0xDE22BE44.
- RD_LATENCY=3: reads of addr 1,2,3 on consecutive edges -> three consecutive rd_valid pulses, the first 3 cycles after the first accept, data in order.
- cs=1 wr_en=1 rd_en=1 to addr 7 holding 0xA5A5A5A5 -> err pulses 1 cycle, no rd_valid, and a later read still returns 0xA5A5A5A5. Same request with cs=0 -> no err.
- Issue a read, then assert reset_n=0 before rd_valid -> rd_valid never pulses, outputs are 0 immediately, and the init sweep restarts.
- SP_RAM_PARITY_EN: write 0xFF00FF00 with inject_par_err=1, byte_en=4'b0011, then read -> parity_err=4'b0011 with rd_valid.

Source files
------------

// File: rtl/sp_ram_ctrl.sv
// ---------------------------------------------------------------------------
// sp_ram_ctrl
//
// Single-port RAM controller with configurable word width and depth. It has
// per-byte write enables, a read pipeline with a programmable latency and a
// valid flag, and a sweep after reset that writes INIT_VALUE to every word
// before requests are accepted.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset_n        asynchronous active-low reset
//   cs             chip select; requests are ignored while low
//   wr_en / rd_en  write / read request; both at once is illegal
//   address_in     word address
//   data_in        write data
//   byte_en        per-byte write enable, bit i covers bits [8i+7:8i]
//   data_out       registered read data; holds between rd_valid pulses
//   rd_valid       one-cycle pulse when data_out is updated
//   ready          high once the init sweep is done
//   err            one-cycle pulse after an illegal read+write request
//
// Optional build macro SP_RAM_PARITY_EN adds:
//   inject_par_err input; inverts the stored parity of the written lanes
//   parity_err     output; per-lane parity failure, qualified by rd_valid
// ---------------------------------------------------------------------------
module sp_ram_ctrl #(
    parameter int                   data_size    = 32,
    parameter int                   address_size = 4,
    parameter int                   RD_LATENCY   = 1,
    parameter logic [data_size-1:0] INIT_VALUE   = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cs,
    input  logic                      wr_en,
    input  logic                      rd_en,
    input  logic [address_size-1:0]   address_in,
    input  logic [data_size-1:0]      data_in,
    input  logic [data_size/8-1:0]    byte_en,
`ifdef SP_RAM_PARITY_EN
    input  logic                      inject_par_err,
    output logic [data_size/8-1:0]    parity_err,
`endif
    output logic [data_size-1:0]      data_out,
    output logic                      rd_valid,
    output logic                      ready,
    output logic                      err
);

    localparam int NB    = data_size / 8;
    localparam int DEPTH = 2 ** address_size;
`ifdef SP_RAM_PARITY_EN
    // Pipeline words carry the per-lane parity result above the data bits.
    localparam int PW = data_size + NB;
`else
    localparam int PW = data_size;
`endif

    typedef enum logic {INIT, IDLE} state_t;

    state_t                    state_q;
    logic [address_size-1:0]   initCnt_q;
    logic                      ready_q;
    logic                      err_q;

    logic [data_size-1:0]      mem_q [DEPTH];

    logic                      initWrite;
    logic                      userWrite;
    logic                      readAccept;
    logic [address_size-1:0]   memAddr_d;
    logic [NB-1:0]             laneWe_d;
    logic [data_size-1:0]      laneData_d;
    logic [PW-1:0]             readWord;

    logic                      lastV;
    logic [PW-1:0]             lastWord;

    logic [data_size-1:0]      dataOut_q;
    logic                      rdValid_q;

    // Request decode. During the sweep the memory port belongs to the init
    // counter and every lane is written; afterwards it follows the request.
    always_comb begin
        initWrite  = (state_q == INIT);
        userWrite  = 1'b0;
        readAccept = 1'b0;
        if ((state_q == IDLE) && ready_q && cs) begin
            userWrite  = wr_en && !rd_en;
            readAccept = rd_en && !wr_en;
        end
        memAddr_d  = initWrite ? initCnt_q : address_in;
        laneData_d = initWrite ? INIT_VALUE : data_in;
        laneWe_d   = '0;
        if (initWrite) begin
            laneWe_d = '1;
        end else if (userWrite) begin
            laneWe_d = byte_en;
        end
    end

    // Control FSM: one pass through INIT writing each address, then IDLE
    // until the next reset. err reflects the request seen at this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= INIT;
            initCnt_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    err_q     <= 1'b0;
                    initCnt_q <= initCnt_q + address_size'(1);
                    if (initCnt_q == address_size'(DEPTH - 1)) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                IDLE: begin
                    err_q <= ready_q && cs && wr_en && rd_en;
                end
                default: begin
                    state_q <= INIT;
                end
            endcase
        end
    end

    // Storage array, byte-lane write. Not reset: the sweep clears it.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (laneWe_d[b]) begin
                mem_q[memAddr_d][8*b +: 8] <= laneData_d[8*b +: 8];
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] parIn_d;
    logic [NB-1:0] parFail;

    // Even parity per lane; injection flips it only for user writes.
    always_comb begin
        parIn_d = '0;
        parFail = '0;
        for (int b = 0; b < NB; b++) begin
            parIn_d[b] = (^laneData_d[8*b +: 8]) ^ (!initWrite && inject_par_err);
            parFail[b] = (^mem_q[address_in][8*b +: 8]) ^ par_q[address_in][b];
        end
        readWord = {parFail, mem_q[address_in]};
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (laneWe_d[b]) begin
                par_q[memAddr_d][b] <= parIn_d[b];
            end
        end
    end
`else
    always_comb begin
        readWord = mem_q[address_in];
    end
`endif

    // Read pipeline. With latency 1 the output register samples memory at
    // the accept edge; longer latencies insert RD_LATENCY-1 stages first.
    generate
        if (RD_LATENCY == 1) begin : gDirect
            assign lastV    = readAccept;
            assign lastWord = readWord;
        end else begin : gPipe
            logic          pipeV_q [RD_LATENCY-1];
            logic [PW-1:0] pipeW_q [RD_LATENCY-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < RD_LATENCY - 1; i++) begin
                        pipeV_q[i] <= 1'b0;
                        pipeW_q[i] <= '0;
                    end
                end else begin
                    pipeV_q[0] <= readAccept;
                    pipeW_q[0] <= readWord;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pipeV_q[i] <= pipeV_q[i-1];
                        pipeW_q[i] <= pipeW_q[i-1];
                    end
                end
            end

            assign lastV    = pipeV_q[RD_LATENCY-2];
            assign lastWord = pipeW_q[RD_LATENCY-2];
        end
    endgenerate

    // Output register: data_out only moves when a read retires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOut_q <= '0;
            rdValid_q <= 1'b0;
        end else begin
            rdValid_q <= lastV;
            if (lastV) begin
                dataOut_q <= lastWord[data_size-1:0];
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] parErr_q;

    // Parity flags are forced low whenever no read is retiring.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parErr_q <= '0;
        end else begin
            parErr_q <= lastV ? lastWord[PW-1 -: NB] : '0;
        end
    end

    assign parity_err = parErr_q;
`endif

    assign data_out = dataOut_q;
    assign rd_valid = rdValid_q;
    assign ready    = ready_q;
    assign err      = err_q;

endmodule
